// File: rtl/axis_hdr_pkg.sv
// Shared types and byte/keep helpers for the AXI-Stream header extractor.
// Helpers work on a fixed maximum width; callers cast to their own beat size.
package axis_hdr_pkg;

  typedef enum logic [1:0] {
    S_FIRST,
    S_BODY,
    S_FLUSH
  } state_t;

  localparam int MAXB = 64;

  typedef logic [MAXB-1:0]   kmask_t;
  typedef logic [MAXB*8-1:0] bmask_t;

  function automatic logic [7:0] keep2cnt(
    input kmask_t k
  );
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < MAXB; i++)
      c = c + 8'(k[i]);
    return c;
  endfunction

  // n ones ending at bit b-1, i.e. MSB-aligned in a b-bit keep.
  function automatic kmask_t cnt2keep(
    input logic [7:0] n,
    input logic [7:0] b
  );
    kmask_t m;
    m = '0;
    for (int i = 0; i < MAXB; i++)
      m[i] = (i < int'(b)) && (i >= int'(b) - int'(n));
    return m;
  endfunction

  function automatic bmask_t keep2mask(
    input kmask_t k
  );
    bmask_t m;
    for (int i = 0; i < MAXB; i++)
      m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

endpackage

// File: rtl/axis_extract_header_merge.sv
// Combinational byte merge: residual bytes followed by the top of the
// current beat, plus the leftover low bytes realigned to the MSB.
module axis_byte_merge
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD/8,
  parameter int LEN_WD       = $clog2(DATA_BYTE_WD)+1
) (
  input  logic [DATA_WD-1:0]      res_data,
  input  logic [LEN_WD-1:0]       res_cnt,
  input  logic [DATA_WD-1:0]      cur_data,
  input  logic [LEN_WD-1:0]       cur_cnt,
  input  logic [LEN_WD-1:0]       hdr_len,
  output logic [DATA_WD-1:0]      merged,
  output logic [DATA_WD-1:0]      residual,
  output logic [DATA_BYTE_WD-1:0] merged_keep
);

  localparam int LW1 = LEN_WD + 1;
  localparam logic [LEN_WD:0] BW = LW1'(DATA_BYTE_WD);

  logic [LEN_WD:0] sum;
  logic [LEN_WD:0] fill;

  assign sum  = {1'b0, res_cnt} + {1'b0, cur_cnt};
  assign fill = (sum > BW) ? BW : sum;

  assign merged   = res_data | (cur_data >> {res_cnt, 3'b000});
  assign residual = cur_data << {hdr_len, 3'b000};

  assign merged_keep =
    DATA_BYTE_WD'(cnt2keep(8'(fill), 8'(DATA_BYTE_WD)));

endmodule

// File: rtl/axis_extract_header.sv
// Strips an H-byte header off each AXI-Stream packet onto a side channel
// and re-aligns the remaining payload to the MSB of the output beat.
module axis_extract_header
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD/8,
  parameter int LEN_WD       = $clog2(DATA_BYTE_WD)+1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_WD-1:0]      i_data,
  input  logic [DATA_BYTE_WD-1:0] i_keep,
  input  logic                    i_last,
  input  logic [LEN_WD-1:0]       i_hdr_len,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DATA_WD-1:0]      o_data,
  output logic [DATA_BYTE_WD-1:0] o_keep,
  output logic                    o_last,
  output logic                    o_hdr_valid,
  input  logic                    i_hdr_ready,
  output logic [DATA_WD-1:0]      o_hdr_data,
  output logic [DATA_BYTE_WD-1:0] o_hdr_keep
);

  localparam logic [LEN_WD-1:0] BL = LEN_WD'(DATA_BYTE_WD);

  state_t state, state_n;

  logic [DATA_WD-1:0]      res_data, din;
  logic [DATA_WD-1:0]      mrg_data, mrg_res;
  logic [DATA_WD-1:0]      out_data_n, hdr_data_n;
  logic [DATA_BYTE_WD-1:0] mrg_keep, out_keep_n, hdr_keep_n;
  logic [LEN_WD-1:0]       res_cnt, res_cnt_n;
  logic [LEN_WD-1:0]       h_reg, hin, h, k, hk;
  logic                    out_free, hdr_free, acc, over;
  logic                    out_ld, out_last_n, hdr_ld, res_ld;

  assign hin = (i_hdr_len == '0 || i_hdr_len > BL) ? BL : i_hdr_len;
  assign h   = (state == S_FIRST) ? hin : h_reg;
  assign k   = LEN_WD'(keep2cnt(kmask_t'(i_keep)));
  assign din = i_data & DATA_WD'(keep2mask(kmask_t'(i_keep)));

  assign over      = k > h;
  assign hk        = over ? h : k;
  assign res_cnt_n = over ? k - h : '0;

  assign out_free = !o_valid || i_ready;
  assign hdr_free = !o_hdr_valid || i_hdr_ready;
  assign acc      = i_valid && o_ready;

  assign hdr_keep_n =
    DATA_BYTE_WD'(cnt2keep(8'(hk), 8'(DATA_BYTE_WD)));
  assign hdr_data_n =
    din & DATA_WD'(keep2mask(kmask_t'(hdr_keep_n)));

  axis_byte_merge #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .LEN_WD       (LEN_WD)
  ) u_merge (
    .res_data    (res_data),
    .res_cnt     (res_cnt),
    .cur_data    (din),
    .cur_cnt     (k),
    .hdr_len     (h),
    .merged      (mrg_data),
    .residual    (mrg_res),
    .merged_keep (mrg_keep)
  );

  always_comb begin
    state_n    = state;
    o_ready    = 1'b0;
    out_ld     = 1'b0;
    out_data_n = mrg_data;
    out_keep_n = mrg_keep;
    out_last_n = 1'b0;
    hdr_ld     = 1'b0;
    res_ld     = 1'b0;
    unique case (state)
      S_FIRST: begin
        o_ready = hdr_free;
        if (acc) begin
          hdr_ld = 1'b1;
          res_ld = 1'b1;
          if (!i_last)   state_n = S_BODY;
          else if (over) state_n = S_FLUSH;
        end
      end
      S_BODY: begin
        o_ready = out_free;
        if (acc) begin
          out_ld     = 1'b1;
          res_ld     = 1'b1;
          out_last_n = i_last && !over;
          if (i_last)
            state_n = over ? S_FLUSH : S_FIRST;
        end
      end
      S_FLUSH: begin
        if (out_free) begin
          out_ld     = 1'b1;
          out_data_n = res_data;
          out_keep_n = DATA_BYTE_WD'(
            cnt2keep(8'(res_cnt), 8'(DATA_BYTE_WD)));
          out_last_n = 1'b1;
          state_n    = S_FIRST;
        end
      end
      default: state_n = S_FIRST;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state       <= S_FIRST;
      res_cnt     <= '0;
      res_data    <= '0;
      h_reg       <= BL;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_keep      <= '0;
      o_last      <= 1'b0;
      o_hdr_valid <= 1'b0;
      o_hdr_data  <= '0;
      o_hdr_keep  <= '0;
    end else begin
      state <= state_n;
      if (out_free) o_valid <= out_ld;
      if (out_ld) begin
        o_data <= out_data_n;
        o_keep <= out_keep_n;
        o_last <= out_last_n;
      end
      if (hdr_free) o_hdr_valid <= hdr_ld;
      if (hdr_ld) begin
        o_hdr_data <= hdr_data_n;
        o_hdr_keep <= hdr_keep_n;
        h_reg      <= hin;
      end
      if (res_ld) begin
        res_data <= mrg_res;
        res_cnt  <= res_cnt_n;
      end
    end
  end

endmodule

// File: doc/axis_extract_header.md
Name: axis_extract_header

Overview:
- Receive-side counterpart of the AXI-Stream header inserter.
- Strips a per-packet header of H bytes (1..DATA_BYTE_WD) from the front of each incoming packet and presents it on a separate header channel.
- Re-aligns the remaining payload bytes to the MSB of the output beat.
- Sits between the link-side stream and the payload consumer; 1-cycle registered output on both channels.

Parameters:
- DATA_WD, 32, stream data width in bits (multiple of 8).
- DATA_BYTE_WD, DATA_WD/8, bytes per beat (B).
- LEN_WD, $clog2(DATA_BYTE_WD)+1, width of i_hdr_len.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-low reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  input beat accepted when i_valid && o_ready.
- i_data  in  DATA_WD  input beat; byte 0 = i_data[DATA_WD-1 -: 8].
- i_keep  in  DATA_BYTE_WD  contiguous from MSB (e.g. 4'b1110); all-ones on non-last beats.
- i_last  in  1  last beat of packet.
- i_hdr_len  in  LEN_WD  header byte count H; sampled on the first beat of each packet.
- o_valid  out  1  payload beat valid.
- i_ready  in  1  payload sink ready.
- o_data  out  DATA_WD  payload beat, MSB-aligned; invalid bytes are zero.
- o_keep  out  DATA_BYTE_WD  payload byte enables, contiguous from MSB.
- o_last  out  1  last payload beat.
- o_hdr_valid  out  1  header valid.
- i_hdr_ready  in  1  header sink ready.
- o_hdr_data  out  DATA_WD  header bytes, MSB-aligned; unused bytes are zero.
- o_hdr_keep  out  DATA_BYTE_WD  header byte enables.

Behaviour:
- Reset (i_reset low at a posedge):
  - Clears o_valid, o_hdr_valid, o_last, o_data, o_keep, o_hdr_data and o_hdr_keep to 0.
  - State goes to S_FIRST; residual count goes to 0.
  - Takes priority over every other event, including mid-packet and S_FLUSH; the in-flight packet is dropped.
- i_hdr_len values of 0 or >B saturate to B.
- Definitions: K = popcount(i_keep); R = B−H = residual byte count.
- Payload output register loads when !o_valid || i_ready.
- Header register loads when !o_hdr_valid || i_hdr_ready.
- S_FIRST:
  - o_ready = !o_hdr_valid || i_hdr_ready.
  - On accept: latch H; header reg = top min(K,H) bytes, with keep to match.
  - Low R bytes are stored as residual.
  - last && K≤H → header only, no payload beat; stay in S_FIRST.
  - last && K>H → S_FLUSH with K−H residual bytes.
  - !last → S_BODY.
- S_BODY:
  - o_ready = !o_valid || i_ready.
  - On accept: output beat = {residual R bytes, top H bytes of i_data}.
  - !last → keep all-ones, o_last=0; new residual = low R bytes.
  - last && K≤H → keep = R+K bytes, o_last=1 → S_FIRST.
  - last && K>H → full beat, o_last=0; residual = K−H bytes → S_FLUSH.
- S_FLUSH:
  - o_ready=0.
  - When the output register is free: load the residual bytes MSB-aligned, keep = residual count, o_last=1 → S_FIRST.
- H=B: R=0; payload passes through unshifted, 1-cycle latency.
- Holding rules: o_data, o_keep and o_last hold while o_valid && !i_ready; header outputs hold while o_hdr_valid && !i_hdr_ready.
- Full throughput: no bubbles in S_BODY with both sinks ready.
- Exactly one extra cycle per packet when the last beat overflows (K>H).
- Input protocol violations (partial keep on a non-last beat, non-contiguous keep): behaviour undefined; the bench flags them via assertion.

Decomposition:
- Package axis_hdr_pkg holds:
  - state enum {S_FIRST, S_BODY, S_FLUSH};
  - functions keep2cnt (popcount of contiguous keep) and cnt2keep (MSB-contiguous mask);
  - byte-mask helpers.
- Sub-module axis_byte_merge (combinational):
  - Inputs: residual word, residual count, current word, H.
  - Outputs: merged word, new residual, merged keep.
  - Instantiated once.

Test Plan:
- B=4, H=2; input beats: 0xAABBCCDD/F, 0x11223344/F, 0x55667788/1100 last.
  - Header: 0xAABB0000, keep 1100.
  - Payload: 0xCCDD1122/F, then 0x33445566/F with o_last=1.
- B=4, H=1; input beats: 0xA1B2C3D4/F, 0x01020304/F last.
  - Header: 0xA1000000, keep 1000.
  - Payload: 0xB2C3D401/F with o_last=0, then flush beat 0x02030400/1110 with o_last=1.
  - o_ready is low during the flush cycle.
- B=4, H=4; input beats: 0xDEADBEEF/F, 0x12345678/1110 last.
  - Header: 0xDEADBEEF/F.
  - Payload: 0x12345600/1110 with o_last=1, unshifted.
- B=4, H=3; single beat 0x0A0B0C0D/1100 last.
  - Header: 0x0A0B0000, keep 1100; no payload beat.
  - Next packet's first beat is accepted on the following cycle.
- Backpressure:
  - Rerun scenario 1 with i_ready low for 5 cycles mid-packet → o_ready drops, outputs hold stable, no byte lost or duplicated.
  - Hold i_hdr_ready low → next packet's first beat is stalled until the header is taken.
- Reset during S_FLUSH of scenario 2 → o_valid=0, o_hdr_valid=0 and state S_FIRST after that edge; the next packet is extracted correctly.
